seq_stream_gen: RTL and testbench
=================================

Name: seq_stream_gen

Overview:
Serial bit-stream generator that pairs with the team's serial pattern detector.
- Accepts a parallel pattern, its length and a repeat count through a valid/ready load handshake.
- Emits the pattern one bit per clock on stream_out, MSB-of-active-length first, repeating it back-to-back.
- Used as the stimulus/transmit end of the stream_in interface in integration and self-checking benches.

Parameters:
PAT_W, 8, maximum pattern length in bits
LEN_W, 4, width of len_in; must hold the value PAT_W
CNT_W, 4, width of repeat_in; total passes = repeat_in + 1

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
load_valid  in  1  load request
load_ready  out  1  block can accept a load (high only in IDLE)
pattern_in  in  PAT_W  pattern bits; bit len-1 is sent first, bit 0 last
len_in  in  LEN_W  active pattern length in bits
repeat_in  in  CNT_W  extra repetitions after the first pass
abort  in  1  synchronous abort of the current transmission
stream_out  out  1  serial data bit
stream_valid  out  1  stream_out carries a pattern bit this cycle
busy  out  1  transmission in progress (state SEND)
done  out  1  one-cycle pulse when all passes complete normally

Behaviour:
- Reset (rst=1 at an edge, including mid-transmission): state IDLE, stream_out=0, stream_valid=0, busy=0, done=0, load_ready=1; all internal counters cleared.
- All outputs are registered.
- States: IDLE, SEND, FIN.
- IDLE:
  - load_ready=1.
  - On a load_valid edge, capture pattern_in, len_eff and repeat_in.
  - len_eff = min(len_in, PAT_W).
  - If len_eff=0: go to FIN; no bits are sent.
  - Otherwise: go to SEND with bit index = len_eff-1 and pass counter = repeat_in.
- SEND:
  - Each cycle drives stream_out = pattern[idx] with stream_valid=1, busy=1, load_ready=0.
  - Latency: the first bit is on stream_out in the cycle immediately after the accepting edge.
  - idx decrements every cycle.
  - When idx=0 and pass counter>0: idx reloads to len_eff-1 and pass counter decrements. There is no gap cycle between passes.
  - When idx=0 and pass counter=0: go to FIN.
- FIN:
  - Lasts one cycle: done=1, stream_valid=0, stream_out=0, busy=0, load_ready=0.
  - Next state IDLE.
  - A new load is accepted the cycle after done, never in the same cycle as done.
- Total SEND duration = len_eff × (repeat_in+1) cycles.
- abort:
  - Sampled in SEND only.
  - At the edge where abort=1, go directly to IDLE: stream_valid=0, stream_out=0, busy=0, load_ready=1 in the next cycle.
  - No done pulse.
  - Ignored in IDLE and FIN.
- rst has priority over abort; abort has priority over normal SEND advance.
- load_valid while load_ready=0 is ignored. It is not queued, and the captured registers do not change.
- pattern_in bits at index ≥ len_eff are don't-care and never transmitted.
- stream_out is 0 whenever stream_valid=0.

Test Plan:
1. Basic send: after reset, load pattern_in=8'b0000_1101, len_in=4, repeat_in=0.
   - Required: stream_out=1,1,0,1 with stream_valid=1 on the 4 cycles following the accept edge.
   - Required: done=1 on cycle 5, load_ready=1 on cycle 6.
2. Repeat and clamp: load pattern_in=8'b1010_0110, len_in=15 (clamped to 8), repeat_in=2.
   - Required: 24 consecutive valid bits, 1,0,1,0,0,1,1,0 three times with no gap.
   - Required: single done pulse after the 24th bit.
3. Zero length: load len_in=0, repeat_in=5.
   - Required: stream_valid never asserts; done=1 exactly one cycle after the accept edge.
4. Abort: load len_in=8, repeat_in=1; assert abort during the 3rd bit cycle.
   - Required: stream_valid=0 and load_ready=1 the next cycle; done never pulses.
5. Reset mid-operation: assert rst during bit 2 of a 4-bit send.
   - Required: next cycle shows all outputs at reset values; a subsequent load transmits correctly from its first bit.
6. Busy load ignored: pulse load_valid with a different pattern during SEND.
   - Required: the original stream is unaltered, and no second transmission starts after done.

Source files
------------

// File: rtl/seq_stream_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_stream_gen_if
// Description : Load handshake and serial stream bundle of the serial
//               bit-stream generator. The slave side is the generator, the
//               master side is whoever loads patterns and consumes the stream.
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_stream_gen_if #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 4
);
  logic             load_valid;
  logic             load_ready;
  logic [PAT_W-1:0] pattern_in;
  logic [LEN_W-1:0] len_in;
  logic [CNT_W-1:0] repeat_in;
  logic             abort;
  logic             stream_out;
  logic             stream_valid;
  logic             busy;
  logic             done;

  modport slave (
    input  load_valid, pattern_in, len_in, repeat_in, abort,
    output load_ready, stream_out, stream_valid, busy, done
  );

  modport master (
    output load_valid, pattern_in, len_in, repeat_in, abort,
    input  load_ready, stream_out, stream_valid, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/seq_stream_gen.sv
`default_nettype none
// ============================================================================
// Module      : seq_stream_gen
// Description : Serial bit-stream generator. Captures a pattern, its length
//               and a repeat count, then emits the pattern MSB-of-length first,
//               one bit per clock, back-to-back for repeat+1 passes.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_stream_gen #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 4
) (
  input  wire logic       clk,
  input  wire logic       rst,
  seq_stream_gen_if.slave bus
);
  // Bit index only needs to address PAT_W positions
  localparam int c_idx_w = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [LEN_W-1:0] c_pat_len = LEN_W'(PAT_W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t             r_state,  w_state_nxt;
  logic [PAT_W-1:0]   r_pat,    w_pat_nxt;
  logic [c_idx_w-1:0] r_len_m1, w_len_m1_nxt;
  logic [c_idx_w-1:0] r_idx,    w_idx_nxt;
  logic [CNT_W-1:0]   r_pass,   w_pass_nxt;
  logic               r_out,    w_out_nxt;
  logic               r_valid,  w_valid_nxt;
  logic               r_busy,   w_busy_nxt;
  logic               r_done,   w_done_nxt;
  logic               r_ready,  w_ready_nxt;

  logic [LEN_W-1:0]   w_len_eff;
  logic [c_idx_w-1:0] w_load_m1;

  // Clamp the requested length to the pattern width; the wrapped value of
  // len-1 for a zero length is never used because that load skips SEND.
  assign w_len_eff = (bus.len_in > c_pat_len) ? c_pat_len : bus.len_in;
  assign w_load_m1 = c_idx_w'(w_len_eff - LEN_W'(1));

  // State, captured load and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_pat    <= '0;
      r_len_m1 <= '0;
      r_idx    <= '0;
      r_pass   <= '0;
      r_out    <= 1'b0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ready  <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_pat    <= w_pat_nxt;
      r_len_m1 <= w_len_m1_nxt;
      r_idx    <= w_idx_nxt;
      r_pass   <= w_pass_nxt;
      r_out    <= w_out_nxt;
      r_valid  <= w_valid_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_ready  <= w_ready_nxt;
    end
  end

  // Next state plus the output values the following cycle must show;
  // r_idx always names the bit currently on stream_out.
  always_comb begin
    w_state_nxt  = r_state;
    w_pat_nxt    = r_pat;
    w_len_m1_nxt = r_len_m1;
    w_idx_nxt    = r_idx;
    w_pass_nxt   = r_pass;
    w_out_nxt    = 1'b0;
    w_valid_nxt  = 1'b0;
    w_busy_nxt   = 1'b0;
    w_done_nxt   = 1'b0;
    w_ready_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.load_valid) begin
          w_pat_nxt    = bus.pattern_in;
          w_len_m1_nxt = w_load_m1;
          w_pass_nxt   = bus.repeat_in;
          if (w_len_eff == '0) begin
            w_state_nxt = S_FIN;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_SEND;
            w_idx_nxt   = w_load_m1;
            w_out_nxt   = bus.pattern_in[w_load_m1];
            w_valid_nxt = 1'b1;
            w_busy_nxt  = 1'b1;
          end
        end else begin
          w_ready_nxt = 1'b1;
        end
      end
      S_SEND: begin
        if (bus.abort) begin
          w_state_nxt = S_IDLE;
          w_ready_nxt = 1'b1;
        end else if (r_idx != '0) begin
          w_idx_nxt   = r_idx - c_idx_w'(1);
          w_out_nxt   = r_pat[w_idx_nxt];
          w_valid_nxt = 1'b1;
          w_busy_nxt  = 1'b1;
        end else if (r_pass != '0) begin
          // Next pass starts without a gap cycle
          w_idx_nxt   = r_len_m1;
          w_pass_nxt  = r_pass - CNT_W'(1);
          w_out_nxt   = r_pat[r_len_m1];
          w_valid_nxt = 1'b1;
          w_busy_nxt  = 1'b1;
        end else begin
          w_state_nxt = S_FIN;
          w_done_nxt  = 1'b1;
        end
      end
      S_FIN: begin
        w_state_nxt = S_IDLE;
        w_ready_nxt = 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_ready_nxt = 1'b1;
      end
    endcase
  end

  assign bus.stream_out   = r_out;
  assign bus.stream_valid = r_valid;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.load_ready   = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_seq_stream_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_stream_gen
// Description : Self-checking bench for seq_stream_gen. A queue-based model
//               predicts every output each cycle; directed vectors carry
//               hand-computed literal expectations as well.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_stream_gen;
  logic clk;
  logic rst;

  seq_stream_gen_if #(.PAT_W(8), .LEN_W(4), .CNT_W(4)) sif ();

  seq_stream_gen #(.PAT_W(8), .LEN_W(4), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  // Output vector order: {load_ready, busy, done, stream_valid, stream_out}
  localparam logic [4:0] c_idle = 5'b10000;
  localparam logic [4:0] c_fin  = 5'b00100;
  localparam logic [4:0] c_s0   = 5'b01010;
  localparam logic [4:0] c_s1   = 5'b01011;
  localparam logic [4:0] c_all  = 5'b11111;

  int         total = 0;
  int         bad   = 0;
  int         cyc_n = 0;
  logic       chk_en = 1'b0;
  logic [4:0] x_mask = '0;
  logic [4:0] x_val  = '0;

  // Model state: expected outputs and the bits still to be sent
  logic [4:0] e = c_idle;
  bit         q[$];
  int         le;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: a load expands into the full list of bits to send
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      e = c_idle;
    end else if (e[4] && sif.load_valid) begin
      le = (int'(sif.len_in) > 8) ? 8 : int'(sif.len_in);
      q.delete();
      for (int p = 0; p <= int'(sif.repeat_in); p++)
        for (int b = le - 1; b >= 0; b--)
          q.push_back(sif.pattern_in[b]);
      if (q.size() == 0) e = c_fin;
      else               e = {4'b0101, q.pop_front()};
    end else if (e[1] && sif.abort) begin
      q.delete();
      e = c_idle;
    end else if (e[1]) begin
      if (q.size() > 0) e = {4'b0101, q.pop_front()};
      else              e = c_fin;
    end else if (e[2]) begin
      e = c_idle;
    end
  end

  // Compare DUT against model and against any literal expectation, mid-cycle
  always @(negedge clk) begin
    logic [4:0] d;
    d = {sif.load_ready, sif.busy, sif.done, sif.stream_valid, sif.stream_out};
    cyc_n++;
    if (chk_en) begin
      total++;
      if (d !== e) begin
        bad++;
        $display("FAIL model cyc=%0d got=%b exp=%b", cyc_n, d, e);
      end
      if (x_mask != '0) begin
        total++;
        if (((d ^ x_val) & x_mask) != '0 || $isunknown(d)) begin
          bad++;
          $display("FAIL literal cyc=%0d got=%b exp=%b mask=%b", cyc_n, d, x_val, x_mask);
        end
      end
    end
  end

  // Advance one edge, then state what the cycle after that edge must show
  task automatic cyc(input logic [4:0] m, input logic [4:0] v);
    @(posedge clk);
    #1;
    x_mask = m;
    x_val  = v;
  endtask

  task automatic set_load(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r);
    sif.load_valid = 1'b1;
    sif.pattern_in = p;
    sif.len_in     = l;
    sif.repeat_in  = r;
  endtask

  function automatic logic [4:0] sb(input logic b);
    return b ? c_s1 : c_s0;
  endfunction

  initial begin
    logic [23:0] t2;
    rst            = 1'b1;
    sif.load_valid = 1'b0;
    sif.pattern_in = '0;
    sif.len_in     = '0;
    sif.repeat_in  = '0;
    sif.abort      = 1'b0;
    cyc('0, '0);
    chk_en = 1'b1;
    cyc(c_all, c_idle);
    rst = 1'b0;
    cyc(c_all, c_idle);

    // 1: basic 4-bit send 1,1,0,1
    set_load(8'b0000_1101, 4'd4, 4'd0);
    cyc(c_all, c_s1);
    sif.load_valid = 1'b0;
    cyc(c_all, c_s1);
    cyc(c_all, c_s0);
    cyc(c_all, c_s1);
    cyc(c_all, c_fin);
    cyc(c_all, c_idle);

    // 2: clamp 15 -> 8, three passes with no gap
    t2 = {3{8'b1010_0110}};
    set_load(8'b1010_0110, 4'd15, 4'd2);
    cyc(c_all, sb(t2[23]));
    sif.load_valid = 1'b0;
    for (int i = 22; i >= 0; i--) cyc(c_all, sb(t2[i]));
    cyc(c_all, c_fin);
    cyc(c_all, c_idle);

    // 3: zero length sends nothing; abort in FIN and IDLE is ignored
    set_load(8'hFF, 4'd0, 4'd5);
    cyc(c_all, c_fin);
    sif.load_valid = 1'b0;
    sif.abort      = 1'b1;
    cyc(c_all, c_idle);
    cyc(c_all, c_idle);
    sif.abort      = 1'b0;

    // 4: abort during the third bit
    set_load(8'b1100_0011, 4'd8, 4'd1);
    cyc(c_all, c_s1);
    sif.load_valid = 1'b0;
    cyc(c_all, c_s1);
    cyc(c_all, c_s0);
    sif.abort = 1'b1;
    cyc(c_all, c_idle);
    sif.abort = 1'b0;
    for (int i = 0; i < 6; i++) cyc(c_all, c_idle);

    // 5: reset during bit 2, then a clean 1,0,0,1 send
    set_load(8'b0000_1011, 4'd4, 4'd0);
    cyc(c_all, c_s1);
    sif.load_valid = 1'b0;
    cyc(c_all, c_s0);
    rst = 1'b1;
    cyc(c_all, c_idle);
    rst = 1'b0;
    set_load(8'b0000_1001, 4'd4, 4'd0);
    cyc(c_all, c_s1);
    sif.load_valid = 1'b0;
    cyc(c_all, c_s0);
    cyc(c_all, c_s0);
    cyc(c_all, c_s1);
    cyc(c_all, c_fin);
    cyc(c_all, c_idle);

    // 6: load during SEND is ignored, no second transmission afterwards
    set_load(8'b1001_0110, 4'd8, 4'd0);
    cyc(c_all, c_s1);
    set_load(8'hFF, 4'd3, 4'd7);
    cyc(c_all, c_s0);
    sif.load_valid = 1'b0;
    cyc(c_all, c_s0);
    cyc(c_all, c_s1);
    cyc(c_all, c_s0);
    cyc(c_all, c_s1);
    cyc(c_all, c_s1);
    cyc(c_all, c_s0);
    cyc(c_all, c_fin);
    for (int i = 0; i < 6; i++) cyc(c_all, c_idle);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
